// File: rtl/window_fill_buffer.sv
// Sliding 3x4 pixel window builder for a column-major pixel stream.
// Publishes a window every two completed columns, with line-end tracking.
module window_fill_buffer #(
   parameter int IMG_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         frame_start,
   input  logic                         pixel_valid,
   input  logic [7:0]                   pixel_in,
   output logic [95:0]                  data_buffer,
   output logic                         enable_calc,
   output logic [$clog2(IMG_WIDTH)-1:0] window_col,
   output logic                         line_done
);

   localparam int CW = $clog2(IMG_WIDTH + 1);
   localparam int WW = $clog2(IMG_WIDTH);
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH);

   logic [1:0]    row_q, row_d, row_b;
   logic [CW-1:0] col_q, col_d, col_b, col_n;
   logic [23:0]   creg_q, creg_d, creg_b;
   logic [95:0]   win_q, win_d, win_b;
   logic [95:0]   buf_q, buf_d;
   logic [WW-1:0] wcol_q, wcol_d;
   logic          en_q, en_d;
   logic          ld_q, ld_d;

   always_comb begin
      // frame_start clears the line state before the same-cycle pixel lands
      row_b  = frame_start ? '0 : row_q;
      col_b  = frame_start ? '0 : col_q;
      creg_b = frame_start ? '0 : creg_q;
      win_b  = frame_start ? '0 : win_q;
      col_n  = col_b + CW'(1);

      row_d  = row_b;
      col_d  = col_b;
      creg_d = creg_b;
      win_d  = win_b;
      buf_d  = buf_q;
      wcol_d = wcol_q;
      en_d   = 1'b0;
      ld_d   = 1'b0;

      if (pixel_valid) begin
         case (row_b)
            2'd0:    creg_d[7:0]   = pixel_in;
            2'd1:    creg_d[15:8]  = pixel_in;
            default: creg_d[23:16] = pixel_in;
         endcase

         if (row_b == 2'd2) begin
            row_d = '0;
            col_d = col_n;
            win_d = {creg_d, win_b[95:24]};
            if (col_n >= CW'(4) && !col_n[0]) begin
               buf_d  = win_d;
               wcol_d = WW'(col_n - CW'(4));
               en_d   = 1'b1;
               if (col_n == COL_MAX) begin
                  ld_d  = 1'b1;
                  col_d = '0;
               end
            end
         end else begin
            row_d = row_b + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q  <= '0;
         col_q  <= '0;
         creg_q <= '0;
         win_q  <= '0;
         buf_q  <= '0;
         wcol_q <= '0;
         en_q   <= 1'b0;
         ld_q   <= 1'b0;
      end else begin
         row_q  <= row_d;
         col_q  <= col_d;
         creg_q <= creg_d;
         win_q  <= win_d;
         buf_q  <= buf_d;
         wcol_q <= wcol_d;
         en_q   <= en_d;
         ld_q   <= ld_d;
      end
   end

   assign data_buffer = buf_q;
   assign enable_calc = en_q;
   assign window_col  = wcol_q;
   assign line_done   = ld_q;

endmodule

// File: tb/tb_window_fill_buffer.sv
// Scoreboard bench for window_fill_buffer: a column-history model
// predicts each published window; a monitor pops and compares.
module tb_window_fill_buffer;

   localparam int W = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic        pixel_valid = 1'b0;
   logic [7:0]  pixel_in = '0;
   logic [95:0] data_buffer;
   logic        enable_calc;
   logic [3:0]  window_col;
   logic        line_done;

   always #5 clk = ~clk;

   window_fill_buffer #(.IMG_WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .pixel_valid (pixel_valid),
      .pixel_in    (pixel_in),
      .data_buffer (data_buffer),
      .enable_calc (enable_calc),
      .window_col  (window_col),
      .line_done   (line_done)
   );

   typedef struct packed {
      logic [95:0] d;
      logic [3:0]  wc;
      logic        ld;
   } exp_t;

   exp_t        q[$];
   exp_t        me;
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_pub = 0;
   int          n_ld  = 0;
   bit          mon_on = 1'b0;
   logic [95:0] last_d = '0;

   logic [7:0]  mrow[3];
   int          mr = 0;
   int          mc = 0;
   logic [23:0] mhist[$];

   task automatic drive(input logic r, input logic fs,
                        input logic v, input logic [7:0] p);
      exp_t e;
      int   n;
      @(negedge clk);
      rst = r; frame_start = fs; pixel_valid = v; pixel_in = p;
      if (r) begin
         mr = 0; mc = 0; mhist.delete(); last_d = '0;
      end else begin
         if (fs) begin
            mr = 0; mc = 0; mhist.delete();
         end
         if (v) begin
            mrow[mr] = p;
            if (mr == 2) begin
               mr = 0;
               mhist.push_back({mrow[2], mrow[1], mrow[0]});
               mc++;
               if (mc >= 4 && mc % 2 == 0) begin
                  n = mhist.size();
                  e.d  = {mhist[n-1], mhist[n-2], mhist[n-3], mhist[n-4]};
                  e.wc = 4'(mc - 4);
                  e.ld = (mc == W);
                  q.push_back(e);
                  if (mc == W) begin
                     mc = 0; mhist.delete();
                  end
               end
            end else begin
               mr++;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // monitor: every pulse must match the head of the scoreboard
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mon_on && enable_calc === 1'b1) begin
            n_pub++;
            if (line_done === 1'b1) n_ld++;
            n_cmp++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL pub_unexpected: got wc=%0d, required no pulse",
                        window_col);
            end else begin
               me = q.pop_front();
               last_d = me.d;
               if (data_buffer !== me.d || window_col !== me.wc ||
                   line_done !== me.ld) begin
                  n_err++;
                  $display("FAIL pub_data: got d=%h wc=%0d ld=%b, required d=%h wc=%0d ld=%b",
                           data_buffer, window_col, line_done,
                           me.d, me.wc, me.ld);
               end
            end
         end else if (mon_on && line_done !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL stray_line_done: got %b, required 0", line_done);
         end
      end
   end

   task automatic check_drained(input string tag);
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL %s_missing_pub: got %0d pending, required 0",
                  tag, q.size());
         q.delete();
      end
   endtask

   task automatic test_reset;
      drive(1'b1, 1'b0, 1'b1, 8'hAA);
      drive(1'b1, 1'b1, 1'b1, 8'h55);
      idle(1);
      n_cmp++;
      if (data_buffer !== '0 || window_col !== 4'd0 ||
          enable_calc !== 1'b0 || line_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset: got d=%h wc=%0d en=%b ld=%b, required all 0",
                  data_buffer, window_col, enable_calc, line_done);
      end
      mon_on = 1'b1;
   endtask

   task automatic test_fill;
      int p0;
      logic [95:0] exp_d;
      exp_d = {{6{8'd200}}, {6{8'd100}}};
      p0 = n_pub;
      for (int i = 0; i < 12; i++)
         drive(1'b0, 1'b0, 1'b1, (i < 6) ? 8'd100 : 8'd200);
      idle(1);
      n_cmp++;
      if (n_pub - p0 != 1 || data_buffer !== exp_d || window_col !== 4'd0) begin
         n_err++;
         $display("FAIL fill: got pubs=%0d d=%h wc=%0d, required 1 %h 0",
                  n_pub - p0, data_buffer, window_col, exp_d);
      end
      check_drained("fill");
   endtask

   task automatic test_hold;
      int p0;
      logic [95:0] exp_d;
      exp_d = {{6{8'd200}}, {6{8'd100}}};
      p0 = n_pub;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'(i + 9));
         idle(1);
         n_cmp++;
         if (data_buffer !== exp_d || window_col !== 4'd0 ||
             enable_calc !== 1'b0) begin
            n_err++;
            $display("FAIL hold: got d=%h wc=%0d en=%b, required %h 0 0",
                     data_buffer, window_col, enable_calc, exp_d);
         end
      end
      n_cmp++;
      if (n_pub != p0) begin
         n_err++;
         $display("FAIL hold_pubs: got %0d, required 0", n_pub - p0);
      end
      check_drained("hold");
   endtask

   task automatic test_stride;
      int p0, l0;
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      p0 = n_pub; l0 = n_ld;
      for (int i = 0; i < 48; i++)
         drive(1'b0, 1'b0, 1'b1, 8'((i * 7 + 3) & 8'hFF));
      idle(1);
      n_cmp++;
      if (n_pub - p0 != 7 || n_ld - l0 != 1 || window_col !== 4'd12) begin
         n_err++;
         $display("FAIL stride: got pubs=%0d lds=%0d wc=%0d, required 7 1 12",
                  n_pub - p0, n_ld - l0, window_col);
      end
      p0 = n_pub;
      for (int i = 0; i < 12; i++)
         drive(1'b0, 1'b0, 1'b1, 8'(i + 40));
      idle(1);
      n_cmp++;
      if (n_pub - p0 != 1 || window_col !== 4'd0) begin
         n_err++;
         $display("FAIL new_line: got pubs=%0d wc=%0d, required 1 0",
                  n_pub - p0, window_col);
      end
      check_drained("stride");
   endtask

   task automatic test_stalls;
      int p0;
      logic [95:0] exp_d;
      exp_d = {{6{8'd200}}, {6{8'd100}}};
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      p0 = n_pub;
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1'b0, 1'b1, (i < 6) ? 8'd100 : 8'd200);
         for (int g = 0; g < 3; g++) begin
            idle(1);
            n_cmp++;
            if (data_buffer !== last_d) begin
               n_err++;
               $display("FAIL stall_hold: got %h, required %h",
                        data_buffer, last_d);
            end
         end
      end
      n_cmp++;
      if (n_pub - p0 != 1 || data_buffer !== exp_d || window_col !== 4'd0) begin
         n_err++;
         $display("FAIL stalls: got pubs=%0d d=%h wc=%0d, required 1 %h 0",
                  n_pub - p0, data_buffer, window_col, exp_d);
      end
      check_drained("stalls");
   endtask

   task automatic test_frame_start;
      int p0;
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 7; i++)
         drive(1'b0, 1'b0, 1'b1, 8'(i + 1));
      drive(1'b0, 1'b1, 1'b1, 8'd50);
      @(posedge clk);
      #1;
      n_cmp++;
      if (enable_calc !== 1'b0 || line_done !== 1'b0) begin
         n_err++;
         $display("FAIL fs_pulse: got en=%b ld=%b, required 0 0",
                  enable_calc, line_done);
      end
      p0 = n_pub;
      for (int i = 0; i < 11; i++)
         drive(1'b0, 1'b0, 1'b1, 8'(i + 60));
      idle(1);
      n_cmp++;
      if (n_pub - p0 != 1 || data_buffer[7:0] !== 8'd50 ||
          window_col !== 4'd0) begin
         n_err++;
         $display("FAIL fs_window: got pubs=%0d d0=%0d wc=%0d, required 1 50 0",
                  n_pub - p0, data_buffer[7:0], window_col);
      end
      check_drained("fs");
   endtask

   task automatic test_reset_mid;
      int p0;
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 20; i++)
         drive(1'b0, 1'b0, 1'b1, 8'(i + 120));
      drive(1'b1, 1'b0, 1'b1, 8'd77);
      idle(1);
      n_cmp++;
      if (data_buffer !== '0 || window_col !== 4'd0 ||
          enable_calc !== 1'b0 || line_done !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: got d=%h wc=%0d en=%b ld=%b, required all 0",
                  data_buffer, window_col, enable_calc, line_done);
      end
      p0 = n_pub;
      for (int i = 0; i < 12; i++)
         drive(1'b0, 1'b0, 1'b1, 8'(i + 200));
      idle(1);
      n_cmp++;
      if (n_pub - p0 != 1 || window_col !== 4'd0) begin
         n_err++;
         $display("FAIL after_reset: got pubs=%0d wc=%0d, required 1 0",
                  n_pub - p0, window_col);
      end
      check_drained("reset_mid");
   endtask

   initial begin
      test_reset();
      test_fill();
      test_hold();
      test_stride();
      test_stalls();
      test_frame_start();
      test_reset_mid();
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
